uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
Buffered 8N1 UART transmitter sitting directly downstream of the core's transmit path. It captures each byte the core presents on sdata during its single-cycle tx_ready strobe into a small FIFO. It then serialises the bytes onto the board TX pin at a fixed baud rate. The core never stalls on transmit, so this block absorbs bursts of back-to-back transmit instructions and flags any byte it had to drop.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); integer >= 2
DEPTH, 16, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous, active-high
tx_ready  input  1  byte-valid strobe from the core; one cycle per byte, no back-pressure
sdata  input  8  byte to send; sampled only when tx_ready=1
txd  output  1  serial line, idles high
busy  output  1  1 while a frame is on the line or the FIFO is non-empty
full  output  1  FIFO holds DEPTH bytes
overflow  output  1  sticky flag, a strobed byte was dropped
count  output  CNT_W  bytes currently queued, excluding the byte being shifted

Behaviour:
- Reset (rst sampled 1 at an edge): values after that edge:
  - txd=1, busy=0, full=0, overflow=0, count=0.
  - FIFO pointers cleared; FSM returns to IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame; txd returns high on the same edge.
- FIFO write: at an edge with tx_ready=1:
  - If count<DEPTH, or a pop occurs on the same edge: write sdata; count += 1 - pop.
  - If count==DEPTH and no pop on that edge: byte discarded, count unchanged, overflow<=1.
  - overflow clears only on rst.
- FSM states and transitions:
  - IDLE: at an edge with count!=0, pop the FIFO head into the shift register and go to START with txd<=0. The pop does not see a byte being written on the same edge, so a strobe into an empty FIFO starts its frame one edge later.
  - START: hold txd=0 for CLK_PER_BIT cycles, then go to DATA with txd<=shift[0] and bit index 0.
  - DATA: hold each bit for CLK_PER_BIT cycles. Bits go out LSB first. After bit 7 completes, go to STOP with txd<=1.
  - STOP: hold txd=1 for CLK_PER_BIT cycles. On completion:
    - if count!=0: pop, go to START, txd<=0 on the same edge (no idle gap between frames);
    - otherwise go to IDLE.
- Frame timing and latency:
  - Frame length is exactly 10*CLK_PER_BIT cycles.
  - Latency: tx_ready high at edge E0 into an empty, idle block makes txd fall at edge E1.
- Baud counter: counts 0..CLK_PER_BIT-1 and wraps. It is reset to 0 on every state transition, so bit timing is exact and has no cumulative drift.
- Status outputs:
  - txd is driven from a flop; no combinational path from any input.
  - busy = (state!=IDLE) | (count!=0), registered-equivalent.
  - full = (count==DEPTH).
- FIFO pointers: log2(DEPTH) bits, wrap naturally. Count is kept separately, so the full and empty cases are unambiguous.
- Bytes presented while tx_ready=0 are ignored. sdata is a don't-care outside the strobe.

Decomposition:
- Shared header/package holds:
  - FSM state encoding: S_IDLE=2'd0, S_START=2'd1, S_DATA=2'd2, S_STOP=2'd3;
  - default CLK_PER_BIT for the 100 MHz board clock.
- One sub-module: sync_fifo. It is parameterised on width (8) and DEPTH, with wr_en, rd_en, dout (registered head), count, full and empty. Any future RX path reuses it.
- The serialiser FSM stays in uart_tx_buffer.

Test Plan:
1. Reset: hold rst=1 for 3 cycles -> txd=1, busy=0, full=0, overflow=0, count=0 throughout and after release.
2. Single byte, CLK_PER_BIT=4: tx_ready=1, sdata=8'h55 at E0.
   - txd falls at E1.
   - Line then carries 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop), each level for exactly 4 cycles.
   - busy drops at E41.
3. Burst, CLK_PER_BIT=4: strobes 8'h01, 8'h80, 8'hA5 on consecutive edges.
   - Three frames back to back, 120 cycles, no idle cycle between stop and next start.
   - Decoded bytes in order 01, 80, A5; count peaks at 2.
4. Overflow, DEPTH=4: six strobes on consecutive edges with data 8'h10..8'h15.
   - Byte 10 pops at E1; bytes 11..14 fill the FIFO; byte 15 is dropped.
   - overflow=1 and stays 1; full=1 for the strobe-6 cycle.
   - Exactly 10, 11, 12, 13, 14 are transmitted.
5. Reset mid-frame, CLK_PER_BIT=4: send 8'hFF, 8'h00; assert rst for one cycle at frame-1 cycle 15.
   - txd=1 immediately after that edge; count=0.
   - No further start bit appears during the 80 cycles that follow.
6. Full with simultaneous pop, DEPTH=4: keep the FIFO at 4 bytes and strobe a fifth byte on the exact edge the STOP-to-START pop occurs.
   - Byte accepted; count stays 4; overflow stays 0.
   - All bytes appear on the line in order.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared state encoding and board defaults for the UART transmit buffer
package uart_tx_buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // 100 MHz board clock at 115200 baud
  localparam int DEFAULT_CLK_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// rtl/uart_tx_buffer_fifo.sv - synchronous FIFO with registered head and explicit occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // A read on the same edge frees a slot, so a full FIFO still accepts the write
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - buffered 8N1 UART transmitter fed by single-cycle byte strobes
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_ready,
  input  logic [7:0]       sdata,
  output logic             txd,
  output logic             busy,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        head;
  logic              fifo_empty;
  logic              bit_done;
  logic              pop;

  assign bit_done = (baud == BAUD_LAST);
  assign pop      = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
  assign busy     = (state != S_IDLE) | ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (tx_ready),
    .din   (sdata),
    .rd_en (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (tx_ready & full & ~pop) begin
        overflow <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_START;
            txd   <= 1'b0;
            baud  <= '0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            txd     <= head[0];
            shift   <= head;
            bit_idx <= '0;
            baud    <= '0;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud <= '0;
            // Chain straight into the next start bit when more bytes are queued
            if (pop) begin
              state <= S_START;
              txd   <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tx_ready = 1'b0;
  logic [7:0]       sdata = 8'h00;
  logic             txd;
  logic             busy;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_fail = 0;
  int ecount = 0;
  int e1;
  int er;
  logic line [0:4095];

  uart_tx_buffer #(
    .CLK_PER_BIT (CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_ready (tx_ready),
    .sdata    (sdata),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  always #5 clk = ~clk;

  // line[k] holds the txd level present after rising edge k
  always @(posedge clk) ecount++;
  always @(negedge clk) if (ecount < 4096) line[ecount] = txd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    tx_ready = 1'b1;
    sdata = b;
    tick();
    tx_ready = 1'b0;
    sdata = 8'h00;
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] v;
    v[3:0] = 4'h0;
    for (int k = 0; k < 8; k++) v[4+4*k +: 4] = {4{b[k]}};
    v[39:36] = 4'hF;
    return v;
  endfunction

  function automatic logic [39:0] window(input int start);
    logic [39:0] v;
    for (int i = 0; i < 40; i++) v[i] = line[start+i];
    return v;
  endfunction

  function automatic logic all_high(input int start, input int n);
    for (int i = 0; i < n; i++) if (line[start+i] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    // reset held for three edges
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", count, 0);
    end
    rst = 1'b0;
    tick();
    chk("idle_txd", txd, 1);
    chk("idle_busy", busy, 0);
    chk("idle_count", count, 0);

    // single byte 0x55
    strobe(8'h55);
    chk("t2_count_e0", count, 1);
    chk("t2_txd_e0", txd, 1);
    chk("t2_busy_e0", busy, 1);
    e1 = ecount + 1;
    tick();
    chk("t2_txd_e1", txd, 0);
    ticks(40);
    chk("t2_frame", window(e1), frame_bits(8'h55));
    chk("t2_busy_e41", busy, 0);
    chk("t2_txd_e41", txd, 1);

    // burst of three back-to-back strobes
    strobe(8'h01);
    strobe(8'h80);
    e1 = ecount;
    chk("t3_count_e1", count, 1);
    strobe(8'hA5);
    chk("t3_count_peak", count, 2);
    ticks(e1 + 121 - ecount);
    chk("t3_frame0", window(e1), frame_bits(8'h01));
    chk("t3_frame1", window(e1 + 40), frame_bits(8'h80));
    chk("t3_frame2", window(e1 + 80), frame_bits(8'hA5));
    chk("t3_idle_after", line[e1+120], 1);
    chk("t3_busy_end", busy, 0);

    // overflow: six strobes into a four-entry FIFO
    strobe(8'h10);
    strobe(8'h11);
    e1 = ecount;
    chk("t4_count_e1", count, 1);
    strobe(8'h12);
    strobe(8'h13);
    strobe(8'h14);
    chk("t4_full_e4", full, 1);
    chk("t4_count_e4", count, 4);
    chk("t4_ovf_e4", overflow, 0);
    strobe(8'h15);
    chk("t4_ovf_e5", overflow, 1);
    chk("t4_count_e5", count, 4);
    ticks(e1 + 201 - ecount);
    chk("t4_frame10", window(e1), frame_bits(8'h10));
    chk("t4_frame11", window(e1 + 40), frame_bits(8'h11));
    chk("t4_frame12", window(e1 + 80), frame_bits(8'h12));
    chk("t4_frame13", window(e1 + 120), frame_bits(8'h13));
    chk("t4_frame14", window(e1 + 160), frame_bits(8'h14));
    chk("t4_no_frame15", line[e1+200], 1);
    chk("t4_busy_end", busy, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // reset in the middle of a frame
    strobe(8'hFF);
    strobe(8'h00);
    e1 = ecount;
    chk("t5_start", txd, 0);
    ticks(14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    er = ecount;
    chk("t5_txd", txd, 1);
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf_cleared", overflow, 0);
    ticks(81);
    chk("t5_line_quiet", all_high(er, 81), 1);
    chk("t5_busy_end", busy, 0);

    // full FIFO with a strobe on the stop-to-start pop edge
    strobe(8'hA0);
    strobe(8'hA1);
    e1 = ecount;
    strobe(8'hA2);
    strobe(8'hA3);
    strobe(8'hA4);
    chk("t6_count_e4", count, 4);
    chk("t6_full_e4", full, 1);
    ticks(e1 + 39 - ecount);
    chk("t6_count_e40", count, 4);
    strobe(8'hA5);
    chk("t6_count_e41", count, 4);
    chk("t6_ovf_e41", overflow, 0);
    chk("t6_txd_e41", txd, 0);
    ticks(e1 + 241 - ecount);
    chk("t6_frameA0", window(e1), frame_bits(8'hA0));
    chk("t6_frameA1", window(e1 + 40), frame_bits(8'hA1));
    chk("t6_frameA2", window(e1 + 80), frame_bits(8'hA2));
    chk("t6_frameA3", window(e1 + 120), frame_bits(8'hA3));
    chk("t6_frameA4", window(e1 + 160), frame_bits(8'hA4));
    chk("t6_frameA5", window(e1 + 200), frame_bits(8'hA5));
    chk("t6_idle_after", line[e1+240], 1);
    chk("t6_busy_end", busy, 0);
    chk("t6_ovf_end", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule
